// File: rtl/ssd_bcd_scanner_if.sv
// ssd_bcd_scanner_if: conversion request/result and display signals of the BCD scanner.
interface ssd_bcd_scanner_if #(
    parameter int BIN_W      = 8,
    parameter int NUM_DIGITS = 4
);
    logic [BIN_W-1:0]        bin_in;
    logic                    load;
    logic                    blank_lz;
    logic                    busy;
    logic                    done;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              cathodes;

    modport master (
        output bin_in, load, blank_lz,
        input  busy, done, bcd_out, an, cathodes
    );

    modport slave (
        input  bin_in, load, blank_lz,
        output busy, done, bcd_out, an, cathodes
    );
endinterface

// File: rtl/ssd_bcd_scanner.sv
// ssd_bcd_scanner: double-dabble binary-to-BCD converter driving a multiplexed
// seven-segment display with optional leading-zero blanking.
module ssd_bcd_scanner #(
    parameter int BIN_W      = 8,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 18
) (
    input logic ClkPort,
    input logic Reset_n,
    ssd_bcd_scanner_if.slave bus
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      sr_q, sr_d;
    logic [DW-1:0]         work_q, work_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         bcd_q, bcd_d;
    logic                  done_q, done_d;
    logic [SCAN_DIV-1:0]   presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            cath_q, cath_d;
    logic [DW-1:0]         adj;
    logic [3:0]            digit;
    logic                  blank;

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            cath_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            cath_q  <= cath_d;
        end
    end

    always_comb begin
        adj = work_q;
        for (int k = 0; k < NUM_DIGITS; k++)
            adj[4*k +: 4] = (work_q[4*k +: 4] > 4'd4) ? work_q[4*k +: 4] + 4'd3 : work_q[4*k +: 4];
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.load) begin
                state_d = SHIFT;
                sr_d    = bus.bin_in;
                work_d  = '0;
                cnt_d   = '0;
            end
            SHIFT: begin
                work_d = {adj[DW-2:0], sr_q[BIN_W-1]};
                sr_d   = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                // The result register is loaded on the last shift so it is valid
                // in the same cycle that done is high.
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = COMMIT;
                    bcd_d   = work_d;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = (&presc_q) ? ((idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1) : idx_q;
        an_d    = ~(NUM_DIGITS'(1) << idx_q);
        digit   = bcd_q[{idx_q, 2'b00} +: 4];
        blank   = bus.blank_lz && (idx_q != '0) && ((bcd_q >> {idx_q, 2'b00}) == '0);
        cath_d  = blank ? 8'hFF : SEG[digit];
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.an       = an_q;
    assign bus.cathodes = cath_q;
endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// tb_ssd_bcd_scanner: directed vectors for conversion latency, load rejection,
// reset abort, display scanning and leading-zero blanking.
module tb_ssd_bcd_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   edges = 0;
    logic [15:0] last_bcd = '0;
    logic [7:0] seg_ref [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    ssd_bcd_scanner_if #(.BIN_W(8), .NUM_DIGITS(4)) if0 ();
    ssd_bcd_scanner_if #(.BIN_W(16), .NUM_DIGITS(5)) if1 ();

    ssd_bcd_scanner #(.BIN_W(8), .NUM_DIGITS(4), .SCAN_DIV(2)) dut0 (
        .ClkPort(clk), .Reset_n(rst_n), .bus(if0.slave));
    ssd_bcd_scanner #(.BIN_W(16), .NUM_DIGITS(5), .SCAN_DIV(2)) dut1 (
        .ClkPort(clk), .Reset_n(rst_n), .bus(if1.slave));

    typedef struct {
        logic [7:0]  bin;
        logic [15:0] bcd;
        int          ign;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load at the current negedge (cycle 0); optionally inject an extra load at cycle ign.
    task automatic conv0(input logic [7:0] b, input logic [15:0] exp, input int ign);
        int dones = 0;
        if0.bin_in = b;
        if0.load   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) if0.load = 1'b0;
            if (c == ign) begin
                if0.bin_in = 8'd17;
                if0.load   = 1'b1;
            end
            if (c == ign + 1) if0.load = 1'b0;
            if (if0.done) dones++;
            chk($sformatf("done c%0d bin%0d", c, b), {31'd0, if0.done}, {31'd0, c == 9});
            chk($sformatf("busy c%0d bin%0d", c, b), {31'd0, if0.busy}, {31'd0, c <= 9});
            if (c < 9) chk($sformatf("hold c%0d bin%0d", c, b), {16'd0, if0.bcd_out}, {16'd0, last_bcd});
            else       chk($sformatf("bcd c%0d bin%0d", c, b), {16'd0, if0.bcd_out}, {16'd0, exp});
        end
        chk($sformatf("done_count bin%0d", b), dones, 1);
        last_bcd = exp;
    endtask

    task automatic conv1(input logic [15:0] b, input logic [19:0] exp);
        if1.bin_in = b;
        if1.load   = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) if1.load = 1'b0;
            chk($sformatf("w16 done c%0d", c), {31'd0, if1.done}, {31'd0, c == 17});
            chk($sformatf("w16 busy c%0d", c), {31'd0, if1.busy}, {31'd0, c <= 17});
            if (c >= 17) chk($sformatf("w16 bcd c%0d", c), {12'd0, if1.bcd_out}, {12'd0, exp});
        end
    endtask

    // Digit shown after k edges since reset release is ((k-1)/4) mod 4 with a 2-bit prescaler.
    task automatic scan0(input logic [15:0] bcd, input logic blz, input int n);
        int idx;
        logic [3:0] d;
        logic [7:0] ec;
        if0.blank_lz = blz;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idx = ((edges - 1) / 4) % 4;
            d   = bcd[4*idx +: 4];
            ec  = (blz && idx > 0 && (bcd >> (4*idx)) == 16'd0) ? 8'hFF : seg_ref[d];
            chk($sformatf("an blz%0d i%0d", blz, i), {28'd0, if0.an}, {28'd0, ~(4'd1 << idx)});
            chk($sformatf("cath blz%0d i%0d", blz, i), {24'd0, if0.cathodes}, {24'd0, ec});
        end
    endtask

    initial begin
        int dones;
        vecs = '{
            '{8'd255, 16'h0255, 0}, '{8'd0,   16'h0000, 0}, '{8'd1,   16'h0001, 0},
            '{8'd9,   16'h0009, 0}, '{8'd10,  16'h0010, 0}, '{8'd99,  16'h0099, 0},
            '{8'd100, 16'h0100, 0}, '{8'd128, 16'h0128, 0}, '{8'd200, 16'h0200, 3},
            '{8'd63,  16'h0063, 0}, '{8'd7,   16'h0007, 0}
        };
        if0.bin_in = '0; if0.load = 1'b0; if0.blank_lz = 1'b0;
        if1.bin_in = '0; if1.load = 1'b0; if1.blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst busy", {31'd0, if0.busy}, 32'd0);
        chk("rst done", {31'd0, if0.done}, 32'd0);
        chk("rst bcd", {16'd0, if0.bcd_out}, 32'd0);
        chk("rst an", {28'd0, if0.an}, 32'hF);
        chk("rst cath", {24'd0, if0.cathodes}, 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first an", {28'd0, if0.an}, 32'hE);
        chk("first cath", {24'd0, if0.cathodes}, 32'h03);

        for (int i = 0; i < 11; i++) conv0(vecs[i].bin, vecs[i].bcd, vecs[i].ign);

        scan0(16'h0007, 1'b1, 20);
        scan0(16'h0007, 1'b0, 20);

        if0.blank_lz = 1'b0;
        if0.bin_in   = 8'd99;
        if0.load     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) if0.load = 1'b0;
        end
        chk("abort busy pre", {31'd0, if0.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, if0.busy}, 32'd0);
        chk("abort done", {31'd0, if0.done}, 32'd0);
        chk("abort bcd", {16'd0, if0.bcd_out}, 32'd0);
        chk("abort an", {28'd0, if0.an}, 32'hF);
        chk("abort cath", {24'd0, if0.cathodes}, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel an", {28'd0, if0.an}, 32'hE);
        chk("rel cath", {24'd0, if0.cathodes}, 32'h03);
        chk("rel bcd", {16'd0, if0.bcd_out}, 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (if0.done) dones++;
        end
        chk("abort no done", dones, 0);
        chk("abort idle", {31'd0, if0.busy}, 32'd0);
        last_bcd = '0;

        conv0(8'd255, 16'h0255, 0);
        conv0(8'd0, 16'h0000, 0);
        scan0(16'h0000, 1'b1, 20);

        conv1(16'd65535, 20'h65535);
        conv1(16'd12345, 20'h12345);
        conv1(16'd1000, 20'h01000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ssd_bcd_scanner.md
SSD_BCD_SCANNER -- requirements
Module: ssd_bcd_scanner

Interface
REQ-001: Parameter BIN_W, default 8, is the width of the unsigned binary input.
REQ-002: Parameter NUM_DIGITS, default 4, is the number of BCD digits and anodes; legal only if 10^NUM_DIGITS > 2^BIN_W-1.
REQ-003: Parameter SCAN_DIV, default 18, is the prescaler width; each digit is lit for 2^SCAN_DIV clocks.
REQ-004: ClkPort  in  1  system clock; all state changes on its rising edge.
REQ-005: Reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-006: bin_in  in  BIN_W  binary value to convert; sampled only on an accepted load.
REQ-007: load  in  1  start-conversion request; single-cycle strobe.
REQ-008: blank_lz  in  1  1 = blank leading zero digits; digit 0 is never blanked.
REQ-009: busy  out  1  high while a conversion is in progress.
REQ-010: done  out  1  one-cycle pulse when a new result is committed.
REQ-011: bcd_out  out  4*NUM_DIGITS  committed BCD result; digit k is at bits [4k+3:4k].
REQ-012: an  out  NUM_DIGITS  anodes, active-low, one-hot-low while scanning.
REQ-013: cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Function
REQ-014: The FSM SHALL have states IDLE, SHIFT and COMMIT.
- IDLE to SHIFT on load=1.
- SHIFT to COMMIT after exactly BIN_W shift cycles.
- COMMIT to IDLE unconditionally.
REQ-015: A load in IDLE SHALL capture bin_in into a shift register, clear the working BCD register, and assert busy from the next cycle.
REQ-016: Each SHIFT cycle SHALL add 3 to every working digit greater than 4, then shift {digits, shift register} left by one.
REQ-017: In COMMIT, the working digits SHALL be copied to bcd_out, done SHALL be 1 for that single cycle, and busy SHALL still be 1.
REQ-018: Latency SHALL be fixed: load accepted at cycle 0 gives done and the new bcd_out at cycle BIN_W+1, and busy=0 at cycle BIN_W+2.
REQ-019: A load while busy=1 (SHIFT or COMMIT) SHALL be ignored: not queued, and the conversion in progress is unaffected.
REQ-020: bcd_out SHALL hold its previous value throughout a conversion and change only in COMMIT.
REQ-021: A SCAN_DIV-bit prescaler SHALL free-run; on its wrap (all ones to 0), the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-022: an SHALL be registered and equal ~(1<<index), so exactly one bit is low outside reset.
REQ-023: cathodes SHALL be registered and decode the indexed digit of bcd_out:
- 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
- 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
- A-F codes per the team SSD table; Dp is always 1.
REQ-024: With blank_lz=1, digit k>0 SHALL drive cathodes=8'hFF when digits k..NUM_DIGITS-1 of bcd_out are all zero; the anode still scans.
REQ-025: A change of blank_lz or bcd_out SHALL take effect on the next registered cathode update, with no glitch beyond one cycle.

Reset
REQ-026: While Reset_n=0, the block SHALL hold:
- state=IDLE, busy=0, done=0, bcd_out=0
- prescaler=0, index=0, an=all ones, cathodes=8'hFF.
REQ-027: Reset assertion mid-conversion SHALL abort it with no done pulse; bcd_out reads 0 after reset.
REQ-028: On the first clock after Reset_n rises, an[0] SHALL go low and cathodes SHALL show digit 0 ("0" = 00000011).

Verification
REQ-029: Defaults, bin_in=255, load at cycle 0 -> done=1 only at cycle 9, bcd_out=16'h0255, busy=0 at cycle 10.
REQ-030: load(200), then load(17) at cycle 3 -> second load ignored; bcd_out=16'h0200; exactly one done pulse.
REQ-031: SCAN_DIV=2, bcd_out=16'h0007:
- blank_lz=1 -> an cycles 1110,1101,1011,0111 every 4 clocks; cathodes 00011111 on an[0] and FF otherwise.
- blank_lz=0 -> "0" on digits 1-3.
REQ-032: Reset_n low at cycle 4 of a conversion of 99 -> busy=0 and done=0 immediately; after release bcd_out=0 and an=1110.
REQ-033: BIN_W=16, NUM_DIGITS=5, bin_in=65535 -> done at cycle 17, bcd_out=20'h65535.
REQ-034: Back-to-back: load(0) accepted at cycle 10 right after the previous busy drops -> done at cycle 19, bcd_out=0, blank_lz=1 shows only digit 0.
